seven_segment_scan_driver: RTL and testbench

- Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display, used for the Pong score readout.
- Holds a shadow copy of N BCD digits, loaded on a strobe so a digit never tears mid-scan.
- Scans one digit per refresh slot, with a programmable blanking gap against ghosting and optional leading-zero suppression.
- Segment encoding is bit6..bit0 = a,b,c,d,e,f,g, active-high before polarity mapping.

---
 rtl/seven_segment_scan_driver.sv | 173 +++++++++++++++++
 tb/tb_seven_segment_scan_driver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed seven-segment scan driver with shadowed BCD digits,
// per-slot blanking gap and optional leading-zero suppression.
//
//   state      | meaning
//   ST_BLANK   | slot start, all anodes and segments off (anti-ghosting gap)
//   ST_DISPLAY | anode[index] on, segments show shadow digit [index]
module seven_segment_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [4*NUM_DIGITS-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_load,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_anode,
    output logic                    o_frame
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]         BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF     = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic {
        ST_BLANK   = 1'b0,
        ST_DISPLAY = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             presc_q, presc_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   dig_q, dig_d;
    logic [NUM_DIGITS-1:0]     dpsh_q, dpsh_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     anode_q, anode_d;
    logic                      frame_q, frame_d;

    logic                      wrap;
    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic                      cur_sup;
    logic [NUM_DIGITS-1:0]     an_sel;
    logic [6:0]                seg_raw;

    function automatic logic [6:0] decode_bcd(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'b1111110;
            4'd1:    pat = 7'b0110000;
            4'd2:    pat = 7'b1101101;
            4'd3:    pat = 7'b1111001;
            4'd4:    pat = 7'b0110011;
            4'd5:    pat = 7'b1011011;
            4'd6:    pat = 7'b1011111;
            4'd7:    pat = 7'b1110000;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1111011;
            4'hF:    pat = 7'b0000000;
            default: pat = 7'b0000001;
        endcase
        return pat;
    endfunction

    always_comb begin
        wrap    = (presc_q == PRESC_LAST);
        presc_d = wrap ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        dig_d  = i_load ? i_digits : dig_q;
        dpsh_d = i_load ? i_dp : dpsh_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // The state tracks the prescaler so that it always describes presc_q.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: begin
                if (presc_d == BLANK_END || BLANK_CYCLES == 0) state_d = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                if (wrap && BLANK_CYCLES != 0) state_d = ST_BLANK;
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // Select the scanned digit; suppression walks down from the top digit.
    always_comb begin
        logic zero_above;
        logic sup_k;
        zero_above = 1'b1;
        sup_k      = 1'b0;
        cur_nib    = 4'hF;
        cur_dp     = 1'b0;
        cur_sup    = 1'b0;
        an_sel     = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            sup_k      = (BLANK_LEADING != 0) && (k != 0) && zero_above
                         && (dig_q[4*k +: 4] == 4'h0);
            zero_above = zero_above && (dig_q[4*k +: 4] == 4'h0);
            if (idx_q == IW'(k)) begin
                cur_nib   = dig_q[4*k +: 4];
                cur_dp    = dpsh_q[k];
                cur_sup   = sup_k;
                an_sel[k] = 1'b1;
            end
        end
    end

    always_comb begin
        anode_d = AN_OFF;
        seg_d   = SEG_OFF;
        dp_d    = DP_OFF;
        seg_raw = cur_sup ? 7'b0000000 : decode_bcd(cur_nib);
        frame_d = (presc_q == '0) && (idx_q == '0);
        if (state_q == ST_DISPLAY) begin
            anode_d = (AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel;
            seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
            dp_d    = cur_dp ^ DP_OFF;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            dig_q   <= '1;
            dpsh_q  <= '0;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
            anode_q <= AN_OFF;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            dpsh_q  <= dpsh_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            anode_q <= anode_d;
            frame_q <= frame_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_dp    = dp_q;
    assign o_anode = anode_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver: 4 digits, 8-cycle slots, 2 blank cycles,
// active-low segments and anodes, leading-zero suppression enabled.
module tb_seven_segment_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic        i_clk;
    logic        i_rst_n;
    logic [15:0] i_digits;
    logic [3:0]  i_dp;
    logic        i_load;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [3:0]  o_anode;
    logic        o_frame;

    seven_segment_scan_driver #(
        .NUM_DIGITS    (ND),
        .REFRESH_DIV   (RD),
        .BLANK_CYCLES  (BC),
        .SEG_ACTIVE_LOW(1),
        .AN_ACTIVE_LOW (1),
        .BLANK_LEADING (1)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_digits(i_digits),
        .i_dp    (i_dp),
        .i_load  (i_load),
        .o_seg   (o_seg),
        .o_dp    (o_dp),
        .o_anode (o_anode),
        .o_frame (o_frame)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cnt;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic [12:0] exp_vec;

    localparam logic [12:0] RESET_VEC = {7'h7F, 1'b1, 4'hF, 1'b0};

    // Active-high segment pattern straight from the digit table.
    function automatic logic [6:0] pattern(input int n);
        case (n)
            0:  return 7'b1111110;
            1:  return 7'b0110000;
            2:  return 7'b1101101;
            3:  return 7'b1111001;
            4:  return 7'b0110011;
            5:  return 7'b1011011;
            6:  return 7'b1011111;
            7:  return 7'b1110000;
            8:  return 7'b1111111;
            9:  return 7'b1111011;
            15: return 7'b0000000;
            default: return 7'b0000001;
        endcase
    endfunction

    // Expected outputs after the next edge, given c edges since reset release.
    function automatic logic [12:0] model_out(input int c, input logic [15:0] sd,
                                              input logic [3:0] sdp);
        int         p;
        int         i;
        int         nib;
        int         above;
        logic [6:0] seg;
        logic [3:0] an;
        logic       fr;
        p     = c % RD;
        i     = (c / RD) % ND;
        fr    = ((c % (RD * ND)) == 0);
        if (p < BC) return {7'h7F, 1'b1, 4'hF, fr};
        above = int'(sd) >> (4 * i);
        nib   = above % 16;
        if (i != 0 && above == 0) seg = 7'b0000000;
        else                      seg = pattern(nib);
        an    = 4'b0001 << i;
        return {~seg, ~sdp[i], ~an, fr};
    endfunction

    function automatic logic [15:0] rand_digits();
        logic [15:0] d;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 2) == 0) d[4*k +: 4] = 4'h0;
            else                           d[4*k +: 4] = 4'($urandom_range(0, 15));
        end
        return d;
    endfunction

    task automatic model_reset();
        cnt   = 0;
        m_dig = 16'hFFFF;
        m_dp  = 4'h0;
    endtask

    // Drive one cycle and advance the model; comparisons live in the tests.
    task automatic step(input logic ld, input logic [15:0] dg, input logic [3:0] dp);
        exp_vec  = model_out(cnt, m_dig, m_dp);
        i_load   = ld;
        i_digits = dg;
        i_dp     = dp;
        @(posedge i_clk);
        #1;
        cnt++;
        if (ld) begin
            m_dig = dg;
            m_dp  = dp;
        end
    endtask

    task automatic test_reset();
        int pulses;
        int last_pulse;
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        n_checks++;
        if ({o_seg, o_dp, o_anode, o_frame} !== RESET_VEC)
            $display("FAIL reset_values got=%h exp=%h", {o_seg, o_dp, o_anode, o_frame}, RESET_VEC);
        else n_pass++;
        i_rst_n = 1'b1;
        model_reset();
        pulses     = 0;
        last_pulse = -1;
        for (int n = 0; n < 70; n++) begin
            step(1'b0, rand_digits(), 4'($urandom_range(0, 15)));
            n_checks++;
            if ({o_seg, o_dp, o_anode, o_frame} !== exp_vec)
                $display("FAIL reset_scan cnt=%0d got=%h exp=%h", cnt, {o_seg, o_dp, o_anode, o_frame}, exp_vec);
            else n_pass++;
            if (o_frame === 1'b1) begin
                if (last_pulse >= 0) begin
                    n_checks++;
                    if (cnt - last_pulse !== ND * RD)
                        $display("FAIL frame_period got=%0d exp=%0d", cnt - last_pulse, ND * RD);
                    else n_pass++;
                end
                last_pulse = cnt;
                pulses++;
            end
        end
        n_checks++;
        if (pulses !== 3) $display("FAIL frame_count got=%0d exp=3", pulses);
        else n_pass++;
    endtask

    task automatic test_digits();
        step(1'b1, 16'h1234, 4'h0);
        for (int n = 0; n < 40; n++) begin
            step(1'b0, rand_digits(), 4'hF);
            n_checks++;
            if ({o_seg, o_dp, o_anode, o_frame} !== exp_vec)
                $display("FAIL digits_1234 cnt=%0d got=%h exp=%h", cnt, {o_seg, o_dp, o_anode, o_frame}, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] pats [2];
        pats[0] = 16'h0007;
        pats[1] = 16'h0000;
        for (int j = 0; j < 2; j++) begin
            step(1'b1, pats[j], 4'h0);
            for (int n = 0; n < 34; n++) begin
                step(1'b0, 16'h0000, 4'h0);
                n_checks++;
                if ({o_seg, o_dp, o_anode, o_frame} !== exp_vec)
                    $display("FAIL leading_zero pat=%h cnt=%0d got=%h exp=%h", pats[j], cnt, {o_seg, o_dp, o_anode, o_frame}, exp_vec);
                else n_pass++;
            end
        end
    endtask

    task automatic test_dash_dp();
        step(1'b1, 16'h1B23, 4'b0100);
        for (int n = 0; n < 34; n++) begin
            step(1'b0, 16'h0000, 4'h0);
            n_checks++;
            if ({o_seg, o_dp, o_anode, o_frame} !== exp_vec)
                $display("FAIL dash_dp cnt=%0d got=%h exp=%h", cnt, {o_seg, o_dp, o_anode, o_frame}, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        while ((cnt % (RD * ND)) != RD + 4) begin
            step(1'b0, 16'h0000, 4'h0);
            n_checks++;
            if ({o_seg, o_dp, o_anode, o_frame} !== exp_vec)
                $display("FAIL align_slot1 cnt=%0d got=%h exp=%h", cnt, {o_seg, o_dp, o_anode, o_frame}, exp_vec);
            else n_pass++;
        end
        step(1'b1, 16'h5678, 4'b0010);
        step(1'b1, 16'h9012, 4'b1000);
        step(1'b1, 16'h0340, 4'b0001);
        for (int n = 0; n < 36; n++) begin
            step(n == 12, 16'h2109, 4'b0110);
            n_checks++;
            if ({o_seg, o_dp, o_anode, o_frame} !== exp_vec)
                $display("FAIL back_to_back cnt=%0d got=%h exp=%h", cnt, {o_seg, o_dp, o_anode, o_frame}, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 7) == 0, rand_digits(), 4'($urandom_range(0, 15)));
            n_checks++;
            if ({o_seg, o_dp, o_anode, o_frame} !== exp_vec)
                $display("FAIL random cnt=%0d got=%h exp=%h", cnt, {o_seg, o_dp, o_anode, o_frame}, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 16'h4321, 4'hF);
        while ((cnt % (RD * ND)) != 2 * RD + 5) begin
            step(1'b0, 16'h0000, 4'h0);
            n_checks++;
            if ({o_seg, o_dp, o_anode, o_frame} !== exp_vec)
                $display("FAIL align_slot2 cnt=%0d got=%h exp=%h", cnt, {o_seg, o_dp, o_anode, o_frame}, exp_vec);
            else n_pass++;
        end
        #1;
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_seg, o_dp, o_anode, o_frame} !== RESET_VEC)
            $display("FAIL reset_async got=%h exp=%h", {o_seg, o_dp, o_anode, o_frame}, RESET_VEC);
        else n_pass++;
        @(posedge i_clk);
        #1;
        n_checks++;
        if ({o_seg, o_dp, o_anode, o_frame} !== RESET_VEC)
            $display("FAIL reset_hold got=%h exp=%h", {o_seg, o_dp, o_anode, o_frame}, RESET_VEC);
        else n_pass++;
        i_rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 12; n++) begin
            step(1'b0, 16'h0000, 4'h0);
            n_checks++;
            if ({o_seg, o_dp, o_anode, o_frame} !== exp_vec)
                $display("FAIL after_reset cnt=%0d got=%h exp=%h", cnt, {o_seg, o_dp, o_anode, o_frame}, exp_vec);
            else n_pass++;
        end
    endtask

    initial begin
        i_rst_n  = 1'b0;
        i_load   = 1'b0;
        i_digits = 16'h0000;
        i_dp     = 4'h0;
        model_reset();
        test_reset();
        test_digits();
        test_leading_zero();
        test_dash_dp();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
